bg_tile_fetcher: RTL and testbench

// Background/window tile fetch sequencer, directly upstream of vram_interface.

---
 rtl/bg_tile_fetcher.sv | 135 +++++++++++++
 tb/tb_bg_tile_fetcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_fetcher.sv
// Background/window tile fetch sequencer: walks the tile map, fetches the low and
// high tile-data bytes for the current line and hands complete rows to the pixel FIFO.
module bg_tile_fetcher #(
  parameter int unsigned       ADDR_W   = 13,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] MAP_BASE = 'h1800
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              fetch_start,
  input  logic              fetch_stop,
  input  logic              fetch_stall,
  input  logic [4:0]        bg_x,
  input  logic [7:0]        bg_y,
  input  logic              map_sel,
  input  logic              tile_sel,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_oe,
  input  logic [DATA_W-1:0] md_in,
  output logic [DATA_W-1:0] tile_lo,
  output logic [DATA_W-1:0] tile_hi,
  output logic              tile_valid,
  input  logic              pipe_ready,
  output logic [4:0]        map_col
);

  typedef enum logic [2:0] {
    StIdle, StMap0, StMap1, StLo0, StLo1, StHi0, StHi1, StPush
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  col_d;
  logic [7:0]  tile_idx;
  logic        cap_idx, cap_lo, cap_hi;
  logic        is_x0;
  logic        hold_off;
  logic        plane;
  logic        b12;
  logic [12:0] tile_addr;
  logic [10:0] map_off;

  // Any control input this cycle suppresses the read strobe and the handshake.
  assign hold_off = fetch_stall | fetch_start | fetch_stop;
  assign is_x0    = (state_q == StMap0) || (state_q == StLo0) || (state_q == StHi0);
  assign plane    = (state_q == StHi0) || (state_q == StHi1);

  // Signed addressing: indices 0..127 live at 'h1000, 128..255 at 'h0800.
  assign b12       = ~(tile_sel | tile_idx[7]);
  assign tile_addr = {b12, tile_idx, bg_y[2:0], plane};
  assign map_off   = {map_sel, bg_y[7:3], map_col};

  assign vram_oe    = is_x0 & ~hold_off;
  assign tile_valid = (state_q == StPush) & ~hold_off;

  always_comb begin
    vram_addr = '0;
    case (state_q)
      StMap0, StMap1:             vram_addr = MAP_BASE | ADDR_W'(map_off);
      StLo0, StLo1, StHi0, StHi1: vram_addr = ADDR_W'(tile_addr);
      default:                    vram_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    col_d   = map_col;
    cap_idx = 1'b0;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    if (fetch_stop) begin
      state_d = StIdle;
      col_d   = '0;
    end else if (fetch_start) begin
      state_d = StMap0;
      col_d   = bg_x;
    end else if (fetch_stall) begin
      // A read interrupted in its second cycle is reissued from its first.
      case (state_q)
        StMap1:  state_d = StMap0;
        StLo1:   state_d = StLo0;
        StHi1:   state_d = StHi0;
        default: state_d = state_q;
      endcase
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StMap0: state_d = StMap1;
        StMap1: begin
          cap_idx = 1'b1;
          state_d = StLo0;
        end
        StLo0: state_d = StLo1;
        StLo1: begin
          cap_lo  = 1'b1;
          state_d = StHi0;
        end
        StHi0: state_d = StHi1;
        StHi1: begin
          cap_hi  = 1'b1;
          state_d = StPush;
        end
        StPush: begin
          if (pipe_ready) begin
            col_d   = map_col + 5'd1;
            state_d = StMap0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      map_col <= '0;
    end else begin
      state_q <= state_d;
      map_col <= col_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tile_idx <= '0;
      tile_lo  <= '0;
      tile_hi  <= '0;
    end else begin
      if (cap_idx) tile_idx <= md_in[7:0];
      if (cap_lo)  tile_lo  <= md_in;
      if (cap_hi)  tile_hi  <= md_in;
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: a small VRAM array answers reads and every
// expected address/data value below is worked out by hand from the map and tile layout.
module tb_bg_tile_fetcher;

  logic        clk;
  logic        nreset;
  logic        fetch_start;
  logic        fetch_stop;
  logic        fetch_stall;
  logic [4:0]  bg_x;
  logic [7:0]  bg_y;
  logic        map_sel;
  logic        tile_sel;
  logic [12:0] vram_addr;
  logic        vram_oe;
  logic [7:0]  md_in;
  logic [7:0]  tile_lo;
  logic [7:0]  tile_hi;
  logic        tile_valid;
  logic        pipe_ready;
  logic [4:0]  map_col;

  logic [7:0] vram [8192];
  int n_checks;
  int n_fail;

  assign md_in = vram[vram_addr];

  bg_tile_fetcher dut (
    .clk         (clk),
    .nreset      (nreset),
    .fetch_start (fetch_start),
    .fetch_stop  (fetch_stop),
    .fetch_stall (fetch_stall),
    .bg_x        (bg_x),
    .bg_y        (bg_y),
    .map_sel     (map_sel),
    .tile_sel    (tile_sel),
    .vram_addr   (vram_addr),
    .vram_oe     (vram_oe),
    .md_in       (md_in),
    .tile_lo     (tile_lo),
    .tile_hi     (tile_hi),
    .tile_valid  (tile_valid),
    .pipe_ready  (pipe_ready),
    .map_col     (map_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [4:0] x);
    bg_x = x;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    nreset      = 1'b0;
    fetch_start = 1'b0;
    fetch_stop  = 1'b0;
    fetch_stall = 1'b0;
    bg_x        = '0;
    bg_y        = '0;
    map_sel     = 1'b0;
    tile_sel    = 1'b1;
    pipe_ready  = 1'b1;
    for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
    vram[13'h1842] = 8'h05;
    vram[13'h0056] = 8'hAA;
    vram[13'h0057] = 8'h55;
    vram[13'h1C04] = 8'h80;
    vram[13'h1C05] = 8'h7F;
    vram[13'h185F] = 8'h12;
    vram[13'h0126] = 8'h3C;
    vram[13'h0127] = 8'hC3;
    vram[13'h1840] = 8'h21;
    vram[13'h0216] = 8'h11;
    vram[13'h0006] = 8'h5A;
    vram[13'h0007] = 8'hA5;

    #12;
    check_eq("rst_addr", 32'(vram_addr), 32'h0);
    check_eq("rst_oe", 32'(vram_oe), 32'h0);
    check_eq("rst_valid", 32'(tile_valid), 32'h0);
    check_eq("rst_lohi", 32'({tile_lo, tile_hi}), 32'h0);
    check_eq("rst_col", 32'(map_col), 32'h0);
    nreset = 1'b1;
    tick();
    check_eq("idle_addr", 32'(vram_addr), 32'h0);

    // Basic row: tile 5, unsigned mode, bg_y='h13, column 2.
    bg_y = 8'h13;
    pulse_start(5'd2);
    check_eq("map0_addr", 32'(vram_addr), 32'h1842);
    check_eq("map0_oe", 32'(vram_oe), 32'h1);
    tick();
    check_eq("map1_addr", 32'(vram_addr), 32'h1842);
    check_eq("map1_oe", 32'(vram_oe), 32'h0);
    tick();
    check_eq("lo0_addr", 32'(vram_addr), 32'h0056);
    check_eq("lo0_oe", 32'(vram_oe), 32'h1);
    tick();
    check_eq("lo1_oe", 32'(vram_oe), 32'h0);
    tick();
    check_eq("hi0_addr", 32'(vram_addr), 32'h0057);
    tick();
    check_eq("hi1_valid", 32'(tile_valid), 32'h0);
    tick();
    check_eq("push_valid", 32'(tile_valid), 32'h1);
    check_eq("push_lo", 32'(tile_lo), 32'hAA);
    check_eq("push_hi", 32'(tile_hi), 32'h55);
    check_eq("push_col", 32'(map_col), 32'd2);
    tick();
    check_eq("acc_valid", 32'(tile_valid), 32'h0);
    check_eq("acc_col", 32'(map_col), 32'd3);
    check_eq("acc_addr", 32'(vram_addr), 32'h1843);

    fetch_stop = 1'b1;
    tick();
    fetch_stop = 1'b0;
    #1;
    check_eq("stop_addr", 32'(vram_addr), 32'h0);
    check_eq("stop_oe", 32'(vram_oe), 32'h0);
    check_eq("stop_col", 32'(map_col), 32'h0);
    check_eq("stop_lo_kept", 32'(tile_lo), 32'hAA);

    // Signed mode, map 'h1C00: tile 'h80 -> 'h0800, tile 'h7F -> 'h17F0.
    tile_sel = 1'b0;
    map_sel  = 1'b1;
    bg_y     = 8'h00;
    pulse_start(5'd4);
    check_eq("sel_map_addr", 32'(vram_addr), 32'h1C04);
    tick();
    tick();
    check_eq("signed80_lo", 32'(vram_addr), 32'h0800);
    pulse_start(5'd5);
    check_eq("restart_map", 32'(vram_addr), 32'h1C05);
    tick();
    tick();
    check_eq("signed7f_lo", 32'(vram_addr), 32'h17F0);
    tick();
    tick();
    check_eq("signed7f_hi", 32'(vram_addr), 32'h17F1);

    // Wrap and backpressure from column 31.
    tile_sel   = 1'b1;
    map_sel    = 1'b0;
    bg_y       = 8'h13;
    pipe_ready = 1'b0;
    pulse_start(5'd31);
    check_eq("wrap_map", 32'(vram_addr), 32'h185F);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(tile_valid), 32'h1);
      check_eq("bp_data", 32'({tile_lo, tile_hi}), 32'h3CC3);
      check_eq("bp_col", 32'(map_col), 32'd31);
      tick();
    end
    pipe_ready = 1'b1;
    #1;
    check_eq("bp_accept_valid", 32'(tile_valid), 32'h1);
    tick();
    check_eq("wrap_col", 32'(map_col), 32'd0);
    check_eq("wrap_addr", 32'(vram_addr), 32'h1840);
    check_eq("wrap_valid", 32'(tile_valid), 32'h0);

    // Stall in LO1: read reissued, post-stall data captured.
    tick();
    tick();
    check_eq("st_lo0_addr", 32'(vram_addr), 32'h0216);
    tick();
    fetch_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("st_oe", 32'(vram_oe), 32'h0);
      check_eq("st_lo_frozen", 32'(tile_lo), 32'h3C);
      if (i == 1) vram[13'h0216] = 8'h99;
      tick();
    end
    fetch_stall = 1'b0;
    #1;
    check_eq("st_reissue_oe", 32'(vram_oe), 32'h1);
    check_eq("st_reissue_addr", 32'(vram_addr), 32'h0216);
    tick();
    tick();
    check_eq("st_lo_new", 32'(tile_lo), 32'h99);
    check_eq("st_hi0_addr", 32'(vram_addr), 32'h0217);

    // Start beats stall in HI0; stop beats start.
    fetch_start = 1'b1;
    fetch_stall = 1'b1;
    bg_x        = 5'd9;
    #1;
    check_eq("col_oe", 32'(vram_oe), 32'h0);
    tick();
    fetch_start = 1'b0;
    fetch_stall = 1'b0;
    #1;
    check_eq("col_start_addr", 32'(vram_addr), 32'h1849);
    check_eq("col_start_oe", 32'(vram_oe), 32'h1);
    check_eq("col_start_col", 32'(map_col), 32'd9);
    fetch_start = 1'b1;
    fetch_stop  = 1'b1;
    tick();
    fetch_start = 1'b0;
    fetch_stop  = 1'b0;
    #1;
    check_eq("col_stop_addr", 32'(vram_addr), 32'h0);
    check_eq("col_stop_oe", 32'(vram_oe), 32'h0);
    check_eq("col_stop_col", 32'(map_col), 32'd0);

    // Async reset while a tile is pending in PUSH.
    pipe_ready = 1'b0;
    pulse_start(5'd3);
    for (int i = 0; i < 6; i++) tick();
    check_eq("pre_rst_valid", 32'(tile_valid), 32'h1);
    check_eq("pre_rst_lo", 32'(tile_lo), 32'h5A);
    #2;
    nreset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(tile_valid), 32'h0);
    check_eq("arst_lohi", 32'({tile_lo, tile_hi}), 32'h0);
    check_eq("arst_col", 32'(map_col), 32'h0);
    check_eq("arst_addr", 32'(vram_addr), 32'h0);
    tick();
    nreset = 1'b1;
    tick();
    check_eq("post_rst_idle", 32'({vram_oe, tile_valid, vram_addr}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
